ula_sequencial: RTL
===================

Name: ula_sequencial

Overview:
Parametrised, clocked successor to the combinational 8-bit ALU. Operand width is generic and all outputs are registered. Multiply and divide are iterative multi-cycle operations; the other operations complete in one cycle. A start/busy/done handshake lets a controller or datapath sequencer issue operations and collect results with comparator and status flags.

Parameters:
LARG, 8, operand width in bits (≥2); Resultado is 2*LARG bits.

Ports:
Clk  input  1  clock, rising edge
Rst_n  input  1  asynchronous active-low reset
Inicio  input  1  request a new operation; accepted only when Ocupado=0
A  input  LARG  operand A, sampled at acceptance
B  input  LARG  operand B, sampled at acceptance
Sel_Op  input  4  opcode, sampled at acceptance
Resultado  output  2*LARG  registered result, held until the next completion
Pronto  output  1  one-cycle pulse when Resultado and flags update
Ocupado  output  1  high while a multi-cycle operation iterates
Carry  output  1  add carry-out; subtract borrow (1 when A<B); else 0
Zero  output  1  Resultado == 0
Erro  output  1  divide by zero or illegal opcode
Maior, Menor, Igual  output  1 each  unsigned compare of the latched A and B, registered with every completion

Behaviour:
- Reset (async, Rst_n=0): state OCIOSO; Resultado=0, Pronto=0, Ocupado=0, Carry=0, Zero=1, Erro=0, Maior=0, Menor=0, Igual=0.
- Opcodes:
  - 0000 add; 0001 sub (mod 2^LARG, zero-extended)
  - 0010 multiply (full 2*LARG product)
  - 0011 quotient; 0100 remainder (zero-extended)
  - 0110 AND; 0111 OR; 1000 NAND; 1001 NOR; 1010 XOR; 1011 NOT A (LARG bits, zero-extended)
  - Any other opcode: Resultado=0, Erro=1, one-cycle latency.
- States: OCIOSO, CALC, FIM. Acceptance happens on an edge where Inicio=1 and the state is OCIOSO or FIM.
  - Single-cycle ops: latch, compute, go to FIM. Pronto is high in the cycle after acceptance (latency 1). Back-to-back issue gives one result per cycle.
  - Multiply and divide: go to CALC. Run LARG iterations: shift-add for multiply, restoring shift-subtract for divide. Ocupado=1 throughout CALC. Then go to FIM. Pronto is high LARG+1 cycles after acceptance.
  - FIM: Pronto=1, Ocupado=0. Go to OCIOSO, or accept a new op if Inicio=1.
- Inicio while Ocupado=1 is ignored, with no queueing. Operand and opcode changes during CALC have no effect.
- Divide by zero (B=0, opcode 0011 or 0100): no iteration; latency 1. Quotient = all ones (zero-extended), remainder = A, Erro=1.
- Erro, Carry, compare flags and Zero update only on the Pronto cycle and hold afterwards.
- Reset asserted mid-CALC aborts immediately to reset values. No Pronto is issued for the aborted op.

Optional Feature:
ULA_SEQ_SATURACAO_EN.
- Defined: add clamps to 2^LARG-1 on carry-out; sub clamps to 0 on borrow. Carry still reports the raw carry/borrow.
- Undefined: add and sub wrap modulo 2^LARG.
- All other opcodes are identical in both builds.

Test Plan:
- LARG=8, A=200, B=100, op 0000 -> next cycle: Pronto=1, Resultado=0x002C, Carry=1, Maior=1. With ULA_SEQ_SATURACAO_EN: Resultado=0x00FF.
- A=5, B=9, op 0001 -> Resultado=0x00FC, Carry=1, Menor=1. With saturation: 0x0000, Zero=1.
- A=200, B=100, op 0010 -> Ocupado=1 for 8 cycles; Pronto 9 cycles after acceptance; Resultado=0x4E20. Inicio pulsed mid-CALC is ignored.
- A=200, B=7: op 0011 -> 0x001C; op 0100 -> 0x0004; each with 9-cycle latency.
- A=0x5A, B=0: op 0011 -> latency 1, Resultado=0x00FF, Erro=1. Op 1111 -> Resultado=0, Erro=1, Zero=1.
- Rst_n low at cycle 4 of a multiply -> all outputs at reset values, no Pronto. Next op 0110 with A=0xF0, B=0x3C -> Resultado=0x0030.

Source files
------------

// File: rtl/ula_sequencial_if.sv
// Operation request and result bundle for the sequential ALU.
// Master issues Inicio/A/B/Sel_Op; slave returns the registered result and flags.
interface ula_sequencial_if #(
  parameter int LARG = 8
);
  logic              Inicio;
  logic [LARG-1:0]   A;
  logic [LARG-1:0]   B;
  logic [3:0]        Sel_Op;
  logic [2*LARG-1:0] Resultado;
  logic              Pronto;
  logic              Ocupado;
  logic              Carry;
  logic              Zero;
  logic              Erro;
  logic              Maior;
  logic              Menor;
  logic              Igual;

  modport master (
    output Inicio, A, B, Sel_Op,
    input  Resultado, Pronto, Ocupado, Carry, Zero, Erro, Maior, Menor, Igual
  );

  modport slave (
    input  Inicio, A, B, Sel_Op,
    output Resultado, Pronto, Ocupado, Carry, Zero, Erro, Maior, Menor, Igual
  );
endinterface

// File: rtl/ula_sequencial.sv
// Sequential ALU: single-cycle logic/add/sub, LARG-iteration shift-add multiply and restoring divide.
// Latency 1 cycle (LARG+1 for mul/div); Inicio ignored while Ocupado. ULA_SEQ_SATURACAO_EN clamps add/sub.
module ula_sequencial #(
  parameter int LARG = 8
) (
  input logic         Clk,
  input logic         Rst_n,
  ula_sequencial_if.slave u
);
  localparam int CW = (LARG > 2) ? $clog2(LARG) : 1;

  localparam logic [3:0] OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_MUL = 4'h2,
                         OP_QUO  = 4'h3, OP_REM  = 4'h4, OP_AND = 4'h6,
                         OP_OR   = 4'h7, OP_NAND = 4'h8, OP_NOR = 4'h9,
                         OP_XOR  = 4'hA, OP_NOT  = 4'hB;

  typedef enum logic [1:0] {OCIOSO, CALC, FIM} estado_t;

  estado_t           estado;
  logic [LARG-1:0]   a_r, b_r, hi, lo;
  logic [3:0]        op_r;
  logic [CW-1:0]     cnt;
  logic [2*LARG-1:0] resultado_q;
  logic              pronto_q, ocupado_q, carry_q, zero_q, erro_q;
  logic              maior_q, menor_q, igual_q;

  // Single-cycle path, evaluated on the live inputs at acceptance.
  logic [LARG:0]     sum, diff;
  logic [2*LARG-1:0] res_s;
  logic              carry_s, erro_s, multi_s;

  always_comb begin
    sum     = {1'b0, u.A} + {1'b0, u.B};
    diff    = {1'b0, u.A} - {1'b0, u.B};
    res_s   = '0;
    carry_s = 1'b0;
    erro_s  = 1'b0;
    multi_s = 1'b0;
    case (u.Sel_Op)
      OP_ADD: begin
        carry_s = sum[LARG];
        res_s   = {{LARG{1'b0}}, sum[LARG-1:0]};
`ifdef ULA_SEQ_SATURACAO_EN
        if (sum[LARG]) res_s = {{LARG{1'b0}}, {LARG{1'b1}}};
`endif
      end
      OP_SUB: begin
        carry_s = diff[LARG];
        res_s   = {{LARG{1'b0}}, diff[LARG-1:0]};
`ifdef ULA_SEQ_SATURACAO_EN
        if (diff[LARG]) res_s = '0;
`endif
      end
      OP_MUL: multi_s = 1'b1;
      OP_QUO, OP_REM: begin
        if (u.B == '0) begin
          erro_s = 1'b1;
          res_s  = (u.Sel_Op == OP_QUO) ? {{LARG{1'b0}}, {LARG{1'b1}}}
                                        : {{LARG{1'b0}}, u.A};
        end else begin
          multi_s = 1'b1;
        end
      end
      OP_AND:  res_s = {{LARG{1'b0}}, u.A & u.B};
      OP_OR:   res_s = {{LARG{1'b0}}, u.A | u.B};
      OP_NAND: res_s = {{LARG{1'b0}}, ~(u.A & u.B)};
      OP_NOR:  res_s = {{LARG{1'b0}}, ~(u.A | u.B)};
      OP_XOR:  res_s = {{LARG{1'b0}}, u.A ^ u.B};
      OP_NOT:  res_s = {{LARG{1'b0}}, ~u.A};
      default: erro_s = 1'b1;
    endcase
  end

  // One iteration; hi/lo hold {product_hi, multiplier} or {remainder, quotient}.
  logic [LARG:0]     mul_s, div_t, div_d;
  logic [LARG-1:0]   hi_n, lo_n;
  logic [2*LARG-1:0] res_m;

  always_comb begin
    mul_s = {1'b0, hi} + (lo[0] ? {1'b0, a_r} : '0);
    div_t = {hi, lo[LARG-1]};
    div_d = div_t - {1'b0, b_r};
    if (op_r == OP_MUL) begin
      hi_n = mul_s[LARG:1];
      lo_n = {mul_s[0], lo[LARG-1:1]};
    end else begin
      hi_n = div_d[LARG] ? div_t[LARG-1:0] : div_d[LARG-1:0];
      lo_n = {lo[LARG-2:0], ~div_d[LARG]};
    end
    case (op_r)
      OP_MUL:  res_m = {hi_n, lo_n};
      OP_QUO:  res_m = {{LARG{1'b0}}, lo_n};
      default: res_m = {{LARG{1'b0}}, hi_n};
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      estado      <= OCIOSO;
      a_r         <= '0;
      b_r         <= '0;
      op_r        <= '0;
      hi          <= '0;
      lo          <= '0;
      cnt         <= '0;
      resultado_q <= '0;
      pronto_q    <= 1'b0;
      ocupado_q   <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b1;
      erro_q      <= 1'b0;
      maior_q     <= 1'b0;
      menor_q     <= 1'b0;
      igual_q     <= 1'b0;
    end else begin
      case (estado)
        OCIOSO, FIM: begin
          if (u.Inicio) begin
            a_r  <= u.A;
            b_r  <= u.B;
            op_r <= u.Sel_Op;
            if (multi_s) begin
              estado    <= CALC;
              ocupado_q <= 1'b1;
              pronto_q  <= 1'b0;
              cnt       <= '0;
              hi        <= '0;
              lo        <= (u.Sel_Op == OP_MUL) ? u.B : u.A;
            end else begin
              estado      <= FIM;
              pronto_q    <= 1'b1;
              resultado_q <= res_s;
              carry_q     <= carry_s;
              erro_q      <= erro_s;
              zero_q      <= (res_s == '0);
              maior_q     <= (u.A > u.B);
              menor_q     <= (u.A < u.B);
              igual_q     <= (u.A == u.B);
            end
          end else begin
            estado   <= OCIOSO;
            pronto_q <= 1'b0;
          end
        end
        CALC: begin
          hi  <= hi_n;
          lo  <= lo_n;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(LARG-1)) begin
            estado      <= FIM;
            ocupado_q   <= 1'b0;
            pronto_q    <= 1'b1;
            resultado_q <= res_m;
            carry_q     <= 1'b0;
            erro_q      <= 1'b0;
            zero_q      <= (res_m == '0);
            maior_q     <= (a_r > b_r);
            menor_q     <= (a_r < b_r);
            igual_q     <= (a_r == b_r);
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  assign u.Resultado = resultado_q;
  assign u.Pronto    = pronto_q;
  assign u.Ocupado   = ocupado_q;
  assign u.Carry     = carry_q;
  assign u.Zero      = zero_q;
  assign u.Erro      = erro_q;
  assign u.Maior     = maior_q;
  assign u.Menor     = menor_q;
  assign u.Igual     = igual_q;
endmodule
